// File: rtl/adder.sv
// Four-stage pipelined ripple adder: one byte-wide slice per stage, with operand
// skew registers feeding later slices and de-skew registers aligning sum slices.

module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          c_i,
  output logic [SW-1:0] s_o,
  output logic          c_o
);
  logic [SW:0] sum;
  assign sum        = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};
  assign {c_o, s_o} = sum;
endmodule

module adder #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 8
) (
  output logic [WIDTH-1:0] si,
  output logic [TAGW-1:0]  xout,
  input  logic [WIDTH-1:0] ai,
  input  logic [WIDTH-1:0] bi,
  input  logic [TAGW-1:0]  xin,
  input  logic             clk,
  input  logic             rst
);
  localparam int NS = 4;
  localparam int SW = WIDTH / NS;

  // Skew storage is packed flat: stage k keeps only the operand bits above its slice.
  function automatic int op_off(input int k);
    int o = 0;
    for (int j = 0; j < k; j++) o += WIDTH - (j + 1) * SW;
    return o;
  endfunction

  // De-skew storage: stage k holds the k+1 completed sum slices.
  function automatic int sm_off(input int k);
    int o = 0;
    for (int j = 0; j < k; j++) o += (j + 1) * SW;
    return o;
  endfunction

  localparam int OPW = op_off(NS - 1);
  localparam int SMW = sm_off(NS);

  logic [OPW-1:0]           a_sk_q, a_sk_d, b_sk_q, b_sk_d;
  logic [SMW-1:0]           s_q, s_d;
  logic [NS-2:0]            c_q, c_d;
  logic [NS-1:0][TAGW-1:0]  x_q;

  for (genvar k = 0; k < NS; k++) begin : g_stg
    localparam int IW = WIDTH - k * SW;
    logic [IW-1:0] a_in, b_in;
    logic          ci, co;
    logic [SW-1:0] s_sl;

    if (k == 0) begin : g_in0
      assign a_in = ai;
      assign b_in = bi;
      assign ci   = 1'b0;
      assign s_d[sm_off(0) +: SW] = s_sl;
    end else begin : g_inn
      assign a_in = a_sk_q[op_off(k-1) +: IW];
      assign b_in = b_sk_q[op_off(k-1) +: IW];
      assign ci   = c_q[k-1];
      assign s_d[sm_off(k) +: (k+1)*SW] = {s_sl, s_q[sm_off(k-1) +: k*SW]};
    end

    adder_slice #(.SW(SW)) u_slice (
      .a_i (a_in[SW-1:0]),
      .b_i (b_in[SW-1:0]),
      .c_i (ci),
      .s_o (s_sl),
      .c_o (co)
    );

    if (k < NS - 1) begin : g_fwd
      assign a_sk_d[op_off(k) +: IW-SW] = a_in[IW-1:SW];
      assign b_sk_d[op_off(k) +: IW-SW] = b_in[IW-1:SW];
      assign c_d[k] = co;
    end else begin : g_last
      // Carry out of the top bit wraps away.
      logic co_unused;
      assign co_unused = co;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sk_q <= '0;
      b_sk_q <= '0;
      s_q    <= '0;
      c_q    <= '0;
      x_q    <= '0;
    end else begin
      a_sk_q <= a_sk_d;
      b_sk_q <= b_sk_d;
      s_q    <= s_d;
      c_q    <= c_d;
      x_q    <= {x_q[NS-2:0], xin};
    end
  end

  assign si   = s_q[sm_off(NS-1) +: WIDTH];
  assign xout = x_q[NS-1];
endmodule

// File: tb/tb_adder.sv
// Bench for adder: queue model of a 4-edge pipeline checked every cycle, plus
// literal expectations for the directed vectors.

module tb_adder;
  logic [31:0] si, ai, bi;
  logic [7:0]  xout, xin;
  logic        clk, rst;

  adder #(.WIDTH(32), .TAGW(8)) dut (
    .si(si), .xout(xout), .ai(ai), .bi(bi), .xin(xin), .clk(clk), .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { logic [31:0] s; logic [7:0] x; } res_t;
  typedef struct { int due; logic [31:0] s; logic [7:0] x; } lit_t;
  res_t mq[$];
  lit_t lq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model: a sum leaves 4 edges after its operands were sampled; reset empties it.
  always @(posedge clk or negedge rst) begin
    if (!rst) mq.delete();
    else begin
      res_t r;
      r.s = ai + bi;
      r.x = xin;
      mq.push_back(r);
      if (mq.size() > 4) void'(mq.pop_front());
    end
  end

  always @(posedge clk) begin
    logic [31:0] es;
    logic [7:0]  ex;
    #2;
    es = (mq.size() == 4) ? mq[0].s : 32'd0;
    ex = (mq.size() == 4) ? mq[0].x : 8'd0;
    chk("model_si", si, es);
    chk("model_xout", {24'd0, xout}, {24'd0, ex});
    while (lq.size() > 0 && lq[0].due <= cyc) begin
      if (lq[0].due < cyc) chk("lit_missed", 32'(lq[0].due), 32'(cyc));
      else begin
        chk("lit_si", si, lq[0].s);
        chk("lit_xout", {24'd0, xout}, {24'd0, lq[0].x});
      end
      void'(lq.pop_front());
    end
  end

  // Drive on the falling edge; a literal expectation is due 4 edges later.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [7:0] x,
                       input bit has_lit, input logic [31:0] es);
    lit_t l;
    @(negedge clk);
    ai = a; bi = b; xin = x;
    if (has_lit) begin
      l.due = cyc + 4; l.s = es; l.x = x;
      lq.push_back(l);
    end
  endtask

  initial begin
    ai = '0; bi = '0; xin = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_si", si, 32'd0);
    chk("reset_xout", {24'd0, xout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    drive(32'd36865,     32'd33023,    "k", 1, 32'd69888);
    drive(32'd9943121,   -32'sd3302367, "a", 1, 32'd6640754);
    drive(-32'sd3686,    32'd3023,     "b", 1, -32'sd663);
    drive(32'd2,         32'd2,        "c", 1, 32'd4);
    drive(32'd4,         32'd4,        "d", 1, 32'd8);
    drive(32'hFFFF_FFFF, 32'd1,        "e", 1, 32'd0);
    drive(32'h7FFF_FFFF, 32'd1,        "f", 1, 32'h8000_0000);
    drive(32'h0000_00FF, 32'd1,        "g", 1, 32'd256);
    drive(32'h0000_FFFF, 32'd1,        "h", 1, 32'h0001_0000);
    drive(32'h00FF_00FF, 32'h0001_0001, "i", 1, 32'h0100_0100);
    drive(32'h8000_0000, 32'h8000_0000, "j", 1, 32'd0);
    for (int i = 1; i <= 6; i++) drive(32'(i * 1000), 32'(i * 7), 8'(8'h30 + i), 0, 32'd0);

    // Pipeline full of nonzero sums; assert reset between edges.
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_si", si, 32'd0);
    chk("async_rst_xout", {24'd0, xout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ai = 32'd5; bi = 32'd6; xin = "z";
    begin
      lit_t l;
      l.due = cyc + 4; l.s = 32'd11; l.x = "z";
      lq.push_back(l);
    end
    drive(32'd0, 32'd0, 8'd0, 0, 32'd0);
    repeat (6) @(negedge clk);

    chk("lit_queue_drained", 32'(lq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/sum width; only 32 is required to work.
REQ-002 Parameter TAGW, default 8, width of the side-band tag carried alongside the data.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ai  input  32  signed two's-complement operand A.
REQ-006 bi  input  32  signed two's-complement operand B.
REQ-007 xin  input  8  tag accompanying the operand pair, e.g. an ASCII character.
REQ-008 si  output  32  signed sum A+B, registered.
REQ-009 xout  output  8  tag matching the sum currently on si, registered.
REQ-010 Port order SHALL be si, xout, ai, bi, xin, clk, rst to support positional instantiation.

Function
REQ-011 The block SHALL be a 4-stage pipelined ripple adder split into four 8-bit slices, bits [7:0], [15:8], [23:16] and [31:24].
REQ-012 Stage k, for k=0..3, SHALL add slice k of the registered operands plus the carry registered by stage k-1; stage 0 carry-in SHALL be 0.
REQ-013 Operand slices not yet consumed SHALL be carried forward through skew registers, and completed sum slices SHALL be carried forward through de-skew registers, so that all 32 sum bits of one operand pair appear on si in the same cycle.
REQ-014 Latency SHALL be exactly 4 rising edges: operands sampled at edge n produce si valid after edge n+3, when the 4th stage register loads.
REQ-015 Throughput SHALL be one new operand pair per clock; there is no handshake, stall or enable.
REQ-016 xin SHALL pass through a 4-deep register chain so that xout always labels the sum on si.
REQ-017 The sum SHALL be (ai+bi) mod 2^32, interpreted as signed.
REQ-018 Overflow SHALL wrap silently, with no flag, and the carry out of bit 31 SHALL be discarded.
REQ-019 The signed and unsigned bit patterns SHALL be identical; no sign-extension logic is required.
REQ-020 Inputs that change every cycle SHALL each produce a distinct, correct result 4 cycles later, with no interference between pipeline entries.

Reset
REQ-021 rst=0 SHALL immediately and asynchronously clear all pipeline, carry, skew and tag registers to 0, so si=0 and xout=0 without waiting for a clock edge.
REQ-022 While rst=0 the registers SHALL hold 0 regardless of clk or inputs.
REQ-023 After rst rises, the first 3 edges SHALL flush zeros to the output (si=0, xout=0).
REQ-024 Valid results SHALL appear from the 4th edge onward.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight sums; no partial result may appear after release.

Verification
REQ-026 ai=36865, bi=33023, xin="k" -> after 4 edges si=69888, xout="k".
REQ-027 ai=9943121, bi=-3302367 -> si=6640754; ai=-3686, bi=3023 -> si=-663, exercising the negative result and the borrow chain across all slices.
REQ-028 Back-to-back pairs (2,2), (4,4), (-1,1), one per clock -> si=4, 8, 0 on consecutive cycles, each with its own xin on xout.
REQ-029 ai=32'h7FFFFFFF, bi=1 -> si=-2147483648 (wrap).
REQ-030 ai=32'h000000FF, bi=1 -> si=256, exercising carry propagation across the slice boundaries.
REQ-031 Assert rst=0 between clock edges while the pipeline is full -> si and xout go to 0 immediately.
REQ-032 Release rst=0 -> si and xout stay 0 for 3 edges before the next valid sum appears.
